// File: rtl/mac_accumulator_if.sv
// Stream/result bundle for mac_accumulator: job start with bias, (act, wgt) input
// stream, result handshake and status. The master drives stimulus; the block is the slave.
interface mac_accumulator_if;
  logic               start;
  logic signed [31:0] bias_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  act_in;
  logic signed [7:0]  wgt_in;
  logic               acc_valid;
  logic               acc_ready;
  logic signed [31:0] acc_out;
  logic               busy;
  logic               sat_flag;

  modport master (
    output start, bias_in, in_valid, act_in, wgt_in, acc_ready,
    input  in_ready, acc_valid, acc_out, busy, sat_flag
  );

  modport slave (
    input  start, bias_in, in_valid, act_in, wgt_in, acc_ready,
    output in_ready, acc_valid, acc_out, busy, sat_flag
  );
endinterface

// File: rtl/mac_accumulator.sv
// Streaming int8 x int8 multiply-accumulate into a bias-seeded 32-bit accumulator.
// Optional feature macro: MAC_SAT_EN (saturating accumulate with sticky sat_flag).
module mac_accumulator #(
  parameter int IN_LEN = 784,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_LEN - 1);

  state_t             state;
  logic signed [31:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_q;
  logic               acc_valid_q;
  logic signed [31:0] acc_out_q;
  logic               busy_q;
  logic               sat_q;

  logic               beat;
  logic signed [15:0] prod;
  logic signed [31:0] acc_next;
  logic               sat_hit;

  assign beat = bus.in_valid && in_ready_q;
  assign prod = $signed(bus.act_in) * $signed(bus.wgt_in);

`ifdef MAC_SAT_EN
  logic signed [32:0] sum_wide;

  // Overflow shows up as the two top bits of the 33-bit sum disagreeing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_next = 32'sd0;
    sum_wide = {acc[31], acc} + {{17{prod[15]}}, prod};
    sat_hit  = (sum_wide[32] != sum_wide[31]);
    if (!sat_hit)
      acc_next = sum_wide[31:0];
    else if (sum_wide[32])
      acc_next = 32'sh8000_0000;
    else
      acc_next = 32'sh7FFF_FFFF;
  end
`else
  always_comb begin
    acc_next = acc + {{16{prod[15]}}, prod};
    sat_hit  = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_out_q   <= '0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= ACCUM;
            acc        <= bus.bias_in;
            cnt        <= '0;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= acc_next;
            cnt   <= cnt + 1'b1;
            sat_q <= sat_q | sat_hit;
            // The result register only moves here, so it is stable for the whole DONE phase.
            if (cnt == LAST_IDX) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              acc_valid_q <= 1'b1;
              acc_out_q   <= acc_next;
            end
          end
        end
        DONE: begin
          if (bus.acc_ready) begin
            state       <= IDLE;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.busy      = busy_q;
  assign bus.sat_flag  = sat_q;

endmodule
